// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit pipeline: data width, opcodes, MEM-stage states.
package proc_pkg;

  localparam int unsigned DW = 16;

  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1100;
  localparam logic [3:0] OP_JLR = 4'b1101;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } mem_state_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// Data-memory access controller. It runs the req/gnt/rvalid handshake FSM, keeps the
// timeout counter and request latches, and owns the sticky bus-error flag.
module mem_req_ctrl import proc_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned DW             = proc_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_op_i,
  input  logic          we_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [DW-1:0] dmem_addr_o,
  output logic [DW-1:0] dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [DW-1:0] dmem_rdata_i,
  output logic          stall_o,
  output mem_state_t    state_o,
  output logic [DW-1:0] rdata_o,
  output logic          timeout_o,
  output logic          bus_err_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          tout_q, tout_d;
  logic          bus_err_q, bus_err_d;
  logic          last_cycle;

  // Last cycle of the REQ+WAIT budget: finish normally if possible, otherwise abandon.
  assign last_cycle = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Next-state, counter and latch updates for the access handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    tout_d    = tout_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StIdle: begin
        if (mem_op_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = we_i;
          cnt_d   = '0;
          rdata_d = '0;   // a timed-out load returns zero
          tout_d  = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d = cnt_q + CntW'(1);
        if (dmem_gnt_i && (we_q || dmem_rvalid_i)) begin
          if (!we_q) rdata_d = dmem_rdata_i;
          state_d = StDone;
        end else if (last_cycle) begin
          tout_d    = 1'b1;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else if (dmem_gnt_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (dmem_rvalid_i) begin
          rdata_d = dmem_rdata_i;
          state_d = StDone;
        end else if (last_cycle) begin
          tout_d    = 1'b1;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      tout_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      tout_q    <= tout_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    dmem_req_o   = (state_q == StReq);
    dmem_we_o    = we_q;
    dmem_addr_o  = addr_q;
    dmem_wdata_o = wdata_q;
    stall_o      = (state_q == StReq) || (state_q == StWait) ||
                   ((state_q == StIdle) && mem_op_i);
    state_o      = state_q;
    rdata_o      = rdata_q;
    timeout_o    = tout_q;
    bus_err_o    = bus_err_q;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage and MEM/WB register: issues LW/SW through mem_req_ctrl and
// registers the write-back bundle, inserting a bubble while an access is in flight.
module mem_stage import proc_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned DW             = proc_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] pc2_in,
  input  logic [DW-1:0] IR_in,
  input  logic          reg_wr_en_in,
  input  logic          mem_wr_en_in,
  input  logic [DW-1:0] D1_in,
  input  logic [DW-1:0] alu_out_in,
  input  logic          carryin,
  input  logic          zeroin,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [DW-1:0] dmem_rdata,
  output logic          stall_out,
  output logic [DW-1:0] pc_out,
  output logic [DW-1:0] pc2_out,
  output logic [DW-1:0] IR_out,
  output logic          reg_wr_en_out,
  output logic [DW-1:0] wb_data_out,
  output logic          carryout,
  output logic          zeroout,
  output logic          bus_err
);

  logic [3:0]    opcode;
  logic          mem_op;
  logic [DW-1:0] wb_sel;
  mem_state_t    state;
  logic [DW-1:0] ld_data;
  logic          timeout;

  logic [DW-1:0] pc_q, pc_d, pc2_q, pc2_d, ir_q, ir_d, wb_q, wb_d;
  logic          rwe_q, rwe_d, c_q, c_d, z_q, z_d;

  assign opcode = IR_in[DW-1 -: 4];
  assign mem_op = mem_wr_en_in || (opcode == OP_LW);
  assign wb_sel = ((opcode == OP_JAL) || (opcode == OP_JLR)) ? pc2_in : alu_out_in;

  mem_req_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .DW            (DW)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .mem_op_i     (mem_op),
    .we_i         (mem_wr_en_in),
    .addr_i       (alu_out_in),
    .wdata_i      (D1_in),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_gnt_i   (dmem_gnt),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .stall_o      (stall_out),
    .state_o      (state),
    .rdata_o      (ld_data),
    .timeout_o    (timeout),
    .bus_err_o    (bus_err)
  );

  // MEM/WB register next state: pass-through, bubble on issue, hold while busy, retire in DONE.
  always_comb begin
    pc_d  = pc_q;
    pc2_d = pc2_q;
    ir_d  = ir_q;
    rwe_d = rwe_q;
    wb_d  = wb_q;
    c_d   = c_q;
    z_d   = z_q;
    unique case (state)
      StIdle: begin
        if (mem_op) begin
          ir_d  = '0;
          rwe_d = 1'b0;
        end else begin
          pc_d  = pc_in;
          pc2_d = pc2_in;
          ir_d  = IR_in;
          rwe_d = reg_wr_en_in;
          wb_d  = wb_sel;
          c_d   = carryin;
          z_d   = zeroin;
        end
      end
      StReq, StWait: ;
      StDone: begin
        // Upstream is frozen, so the inputs still carry the memory instruction.
        pc_d  = pc_in;
        pc2_d = pc2_in;
        ir_d  = IR_in;
        c_d   = carryin;
        if (dmem_we) begin
          rwe_d = 1'b0;
          wb_d  = wb_sel;
          z_d   = zeroin;
        end else begin
          rwe_d = reg_wr_en_in && !timeout;
          wb_d  = ld_data;
          z_d   = (ld_data == '0);
        end
      end
      default: ;
    endcase
  end

  // MEM/WB register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      pc2_q <= '0;
      ir_q  <= '0;
      rwe_q <= 1'b0;
      wb_q  <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      pc2_q <= pc2_d;
      ir_q  <= ir_d;
      rwe_q <= rwe_d;
      wb_q  <= wb_d;
      c_q   <= c_d;
      z_q   <= z_d;
    end
  end

  assign pc_out        = pc_q;
  assign pc2_out       = pc2_q;
  assign IR_out        = ir_q;
  assign reg_wr_en_out = rwe_q;
  assign wb_data_out   = wb_q;
  assign carryout      = c_q;
  assign zeroout       = z_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: a transaction-level model predicts stall length,
// bus activity and the retired write-back bundle; a small memory array answers requests.
module tb_mem_stage;

  localparam int unsigned TO = 8;

  logic        clk, rst;
  logic [15:0] pc_in, pc2_in, IR_in, D1_in, alu_out_in;
  logic        reg_wr_en_in, mem_wr_en_in, carryin, zeroin;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_out, reg_wr_en_out, carryout, zeroout, bus_err;
  logic [15:0] pc_out, pc2_out, IR_out, wb_data_out;

  mem_stage #(
    .TIMEOUT_CYCLES(TO),
    .DW            (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .pc2_in       (pc2_in),
    .IR_in        (IR_in),
    .reg_wr_en_in (reg_wr_en_in),
    .mem_wr_en_in (mem_wr_en_in),
    .D1_in        (D1_in),
    .alu_out_in   (alu_out_in),
    .carryin      (carryin),
    .zeroin       (zeroin),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .stall_out    (stall_out),
    .pc_out       (pc_out),
    .pc2_out      (pc2_out),
    .IR_out       (IR_out),
    .reg_wr_en_out(reg_wr_en_out),
    .wb_data_out  (wb_data_out),
    .carryout     (carryout),
    .zeroout      (zeroout),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mem     [16];  // responder storage, written from the DUT's bus
  logic [15:0] ref_mem [16];  // model storage, written from stimulus

  logic [15:0] e_pc, e_pc2, e_ir, e_wb;
  logic        e_rwe, e_c, e_z, e_berr;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, ".pc"},   pc_out,               e_pc);
    check_eq({tag, ".pc2"},  pc2_out,              e_pc2);
    check_eq({tag, ".ir"},   IR_out,               e_ir);
    check_eq({tag, ".rwe"},  16'(reg_wr_en_out),   16'(e_rwe));
    check_eq({tag, ".wb"},   wb_data_out,          e_wb);
    check_eq({tag, ".c"},    16'(carryout),        16'(e_c));
    check_eq({tag, ".z"},    16'(zeroout),         16'(e_z));
    check_eq({tag, ".berr"}, 16'(bus_err),         16'(e_berr));
  endtask

  task automatic clear_model();
    e_pc = '0; e_pc2 = '0; e_ir = '0; e_wb = '0;
    e_rwe = 1'b0; e_c = 1'b0; e_z = 1'b0; e_berr = 1'b0;
  endtask

  // One instruction from arrival to retirement. g: REQ cycles before gnt; r: cycles
  // from gnt to rvalid (0 = same cycle). Called just after a rising edge.
  task automatic run_instr(input logic [15:0] pc, input logic [15:0] ir,
                           input logic [15:0] alu, input logic [15:0] d1,
                           input logic rwe, input logic mwe, input logic c, input logic z,
                           input int g, input int r);
    logic        is_mem, is_st, to, in_req;
    logic [15:0] sel;
    int          needed, busy;
    is_st  = mwe;
    is_mem = mwe || (ir[15:12] == 4'h4);
    pc_in = pc; pc2_in = pc + 16'd1; IR_in = ir; alu_out_in = alu; D1_in = d1;
    reg_wr_en_in = rwe; mem_wr_en_in = mwe; carryin = c; zeroin = z;
    sel = (ir[15:12] == 4'hC || ir[15:12] == 4'hD) ? pc + 16'd1 : alu;
    dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check_eq("arrive.stall", 16'(stall_out), 16'(is_mem));
    check_eq("arrive.req",   16'(dmem_req),  16'd0);
    if (!is_mem) begin
      tick();
      e_pc = pc; e_pc2 = pc + 16'd1; e_ir = ir; e_rwe = rwe; e_wb = sel; e_c = c; e_z = z;
      check_outs("pass");
      return;
    end
    tick();
    e_ir = '0; e_rwe = 1'b0;
    check_outs("bubble");
    needed = g + 1 + (is_st ? 0 : r);
    to     = needed > int'(TO);
    busy   = to ? int'(TO) : needed;
    for (int k = 0; k < busy; k++) begin
      in_req      = (k <= g);
      dmem_gnt    = (k == g) || (k > g && 1'($urandom) == 1'b1);
      dmem_rvalid = !is_st && (k == g + r);
      dmem_rdata  = 16'($urandom);
      #1;
      if (dmem_rvalid) dmem_rdata = mem[dmem_addr[3:0]];
      check_eq("busy.stall", 16'(stall_out), 16'd1);
      check_eq("busy.req",   16'(dmem_req),  16'(in_req));
      if (in_req) begin
        check_eq("req.addr",  dmem_addr,        alu);
        check_eq("req.we",    16'(dmem_we),     16'(mwe));
        check_eq("req.wdata", dmem_wdata,       d1);
      end
      if (dmem_req && dmem_gnt && dmem_we) mem[dmem_addr[3:0]] = dmem_wdata;
      tick();
    end
    dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = 16'($urandom);
    #1;
    check_eq("done.stall", 16'(stall_out), 16'd0);
    check_eq("done.req",   16'(dmem_req),  16'd0);
    e_pc = pc; e_pc2 = pc + 16'd1; e_ir = ir; e_c = c;
    if (is_st) begin
      e_rwe = 1'b0; e_wb = sel; e_z = z;
      if (!to) ref_mem[alu[3:0]] = d1;
    end else if (to) begin
      e_rwe = 1'b0; e_wb = '0; e_z = 1'b1;
    end else begin
      e_wb = ref_mem[alu[3:0]]; e_rwe = rwe; e_z = (e_wb == 16'd0);
    end
    if (to) e_berr = 1'b1;
    tick();
    check_outs("retire");
  endtask

  task automatic random_instr();
    logic [3:0]  op;
    logic [15:0] ir;
    logic        mwe, rwe;
    int          kind, g;
    kind = int'($urandom_range(0, 3));
    rwe  = 1'($urandom);
    mwe  = 1'b0;
    op   = 4'($urandom);
    unique case (kind)
      0: begin
        if (op == 4'h4 || op == 4'h5) op = op + 4'h8;
        ir = {op, 12'($urandom)};
      end
      1: ir = {4'h4, 12'($urandom)};
      2: begin ir = {4'h5, 12'($urandom)}; mwe = 1'b1; end
      default: begin ir = '0; rwe = 1'b0; end
    endcase
    g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
    run_instr(16'($urandom), ir, 16'($urandom), 16'($urandom), rwe, mwe,
              1'($urandom), 1'($urandom), g, int'($urandom_range(0, 3)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    pc_in = '0; pc2_in = '0; IR_in = '0; D1_in = '0; alu_out_in = '0;
    reg_wr_en_in = 1'b0; mem_wr_en_in = 1'b0; carryin = 1'b0; zeroin = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0] = 16'd0; ref_mem[0] = 16'd0;
    clear_model();
    #2;
    check_outs("reset");
    check_eq("reset.req",   16'(dmem_req),  16'd0);
    check_eq("reset.stall", 16'(stall_out), 16'd0);
    @(posedge clk); #3; rst = 1'b1;
    tick();

    // Directed cases: ADD, LW of zero, delayed-grant SW, JAL, timed-out LW.
    run_instr(16'h0010, 16'h1050, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(16'h0011, 16'h4000, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1);
    run_instr(16'h0012, 16'h5000, 16'h0080, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 3, 0);
    run_instr(16'h0010, 16'hC000, 16'h7777, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    run_instr(16'h0020, 16'h4123, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 20, 0);
    run_instr(16'h0021, 16'h1000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 80; i++) random_instr();

    // Asynchronous reset while a load sits in WAIT; the late rvalid must be ignored.
    pc_in = 16'h0100; pc2_in = 16'h0101; IR_in = 16'h4000; alu_out_in = 16'h0003;
    reg_wr_en_in = 1'b1; mem_wr_en_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    tick();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #2; rst = 1'b0; #1;
    clear_model();
    check_eq("rst_mid.req", 16'(dmem_req), 16'd0);
    check_outs("rst_mid");
    pc_in = '0; pc2_in = '0; IR_in = '0; alu_out_in = '0; D1_in = '0;
    reg_wr_en_in = 1'b0; carryin = 1'b0; zeroin = 1'b0;
    tick();
    #2; rst = 1'b1;
    tick();
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 16'hFFFF;
    tick();
    dmem_rvalid = 1'b0;
    tick();
    check_outs("late_rvalid");
    check_eq("late_rvalid.req",   16'(dmem_req),  16'd0);
    check_eq("late_rvalid.stall", 16'(stall_out), 16'd0);

    for (int i = 0; i < 12; i++) random_instr();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
